unified_stream_unpacker: RTL and testbench
==========================================

UNIFIED_STREAM_UNPACKER -- requirements
Module: unified_stream_unpacker

Interface
REQ-001 Parameter FRAME_LEN, default 8, number of samples per FFT frame (legal range 2..256).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer has a unified-format sample on in_data.
REQ-005 in_ready  output  1  block accepts the sample on this edge when in_valid=1.
REQ-006 in_data  input  24  unified sample: [23:16] FP8 real, [15:8] FP8 imag, [7:4] FP4 real, [3:0] FP4 imag.
REQ-007 in_prec  input  1  precision of the in_data field: 0 = FP4 field [7:0] valid, 1 = FP8 field [23:8] valid.
REQ-008 out_valid  output  1  out_data/out_last hold a sample.
REQ-009 out_ready  input  1  consumer takes the sample on this edge when out_valid=1.
REQ-010 out_data  output  16  FP8 E4M3 complex sample: [15:8] real, [7:0] imag.
REQ-011 out_last  output  1  marks the final sample of a frame.
REQ-012 out_widened  output  1  sample came from the FP4 field (in_prec=0 at acceptance).

Function
REQ-013 Input transfer occurs on a clk edge with in_valid=1 and in_ready=1; output transfer occurs on an edge with out_valid=1 and out_ready=1.
REQ-014 Storage is a 2-entry FIFO of {data[15:0], last, widened}; in_ready = (occupancy < 2) and not rst, with no combinational path from out_ready to in_ready.
REQ-015 Latency: a sample accepted at edge t into an empty FIFO is presented with out_valid=1 after edge t (one cycle), and there is no combinational in-to-out path.
REQ-016 Ordering is strictly FIFO; out_data/out_last/out_widened stay stable while out_valid=1 and out_ready=0.
REQ-017 Simultaneous push and pop at occupancy 1 keeps occupancy 1; at occupancy 2 only a pop occurs (in_ready=0).
REQ-018 FP8 path (in_prec=1): out_data = in_data[23:8] unchanged.
REQ-019 FP4 path (in_prec=0): each 4-bit E2M1 nibble {s,e[1:0],m} converts independently to 8-bit E4M3 {s,E[3:0],M[2:0]}.
REQ-020 Rule: e=0,m=0 -> {s,0000,000} (signed zero preserved); e=0,m=1 -> {s,0110,000}; e!=0 -> E=e+6, M={m,00}; the conversion is exact, with no rounding and no saturation.
REQ-021 The frame counter counts accepted inputs from 0 to FRAME_LEN-1; the entry accepted at count FRAME_LEN-1 is stored with last=1, and the counter then wraps to 0.
REQ-022 Precision may change on any sample, including mid-frame, and does not affect the frame count.
REQ-023 When out_valid=0, out_data, out_last and out_widened are 0.

Reset
REQ-024 While rst=1 on an edge: FIFO is emptied, frame counter is 0, out_valid=0, out_data=0, out_last=0, out_widened=0; in_ready=0 while rst is high.
REQ-025 Reset mid-frame or with a full FIFO discards all stored samples and the partial frame count; the first sample after reset is frame position 0.
REQ-026 The first accept is possible on the first edge with rst=0.

Verification
REQ-027 FP4 convert: in_prec=0, in_data=0x00003A, out_ready=1 -> next cycle out_data=0x3CB8, out_widened=1.
REQ-028 FP4 edge values: nibbles 0x1/0x8 -> 0x30/0x80; nibbles 0x7/0xF -> 0x4C/0xCC.
REQ-029 FP8 pass-through: in_prec=1, in_data=0xA5C3FF -> out_data=0xA5C3, out_widened=0.
REQ-030 Backpressure: out_ready=0, 3 samples offered -> 2 accepted, in_ready=0 on the 3rd; release out_ready -> samples emerge in order, none lost or duplicated.
REQ-031 Framing: FRAME_LEN=8, 16 back-to-back samples with alternating in_prec -> out_last=1 only on outputs 8 and 16.
REQ-032 Reset mid-frame: accept 5 samples, assert rst 1 cycle, then 8 samples -> out_valid=0 after reset, out_last on the 8th post-reset sample only.

Source files
------------

// File: rtl/unified_stream_unpacker.sv
// unified_stream_unpacker
//   Takes unified-format complex samples (FP8 pair in [23:8], FP4 pair in [7:0]),
//   selects the field indicated by in_prec, widens FP4 E2M1 to FP8 E4M3 exactly,
//   and buffers the result in a 2-entry FIFO tagged with frame-last and widened flags.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data  input stream (24-bit unified sample)
//   in_prec                    0 = FP4 field valid, 1 = FP8 field valid
//   out_valid/out_ready        output stream handshake
//   out_data                   FP8 E4M3 complex sample {real, imag}
//   out_last                   final sample of a FRAME_LEN-sample frame
//   out_widened                sample was converted from the FP4 field
module unified_stream_unpacker #(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_prec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        out_widened
);

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        widened;
    } entry_t;

    // E2M1 -> E4M3: bias moves from 1 to 7, so normals gain 6 on the exponent.
    // The single E2M1 subnormal (0.5) is a normal in E4M3 (exponent 6, mantissa 0).
    function automatic logic [7:0] fp4_to_fp8(input logic [3:0] nib);
        logic       s;
        logic [1:0] e;
        logic       m;
        logic [7:0] res;
        s = nib[3];
        e = nib[2:1];
        m = nib[0];
        if (e == 2'b00) begin
            res = m ? {s, 4'b0110, 3'b000} : {s, 7'b0000000};
        end else begin
            res = {s, {2'b00, e} + 4'd6, m, 2'b00};
        end
        return res;
    endfunction

    entry_t           mem_q [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic   push;
    logic   pop;
    entry_t new_entry;
    entry_t head;

    // in_ready depends only on registered occupancy and rst, never on out_ready.
    assign in_ready = (count_q != 2'd2) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        new_entry.widened = !in_prec;
        new_entry.last    = (frame_cnt_q == LAST_POS);
        if (in_prec) begin
            new_entry.data = in_data[23:8];
        end else begin
            new_entry.data = {fp4_to_fp8(in_data[7:4]), fp4_to_fp8(in_data[3:0])};
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        frame_cnt_d = frame_cnt_q;
        if (push) begin
            wr_ptr_d    = ~wr_ptr_q;
            frame_cnt_d = (frame_cnt_q == LAST_POS) ? '0 : frame_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            frame_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign out_valid   = (count_q != 2'd0);
    assign head        = mem_q[rd_ptr_q];
    assign out_data    = out_valid ? head.data : 16'h0000;
    assign out_last    = out_valid ? head.last : 1'b0;
    assign out_widened = out_valid ? head.widened : 1'b0;

endmodule

// File: tb/tb_unified_stream_unpacker.sv
module tb_unified_stream_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_prec;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_widened;

    int checks = 0;
    int errors = 0;

    unified_stream_unpacker #(
        .FRAME_LEN(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_prec    (in_prec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_widened(out_widened)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle outputs away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_data;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 24'h0;
        in_prec   = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_out_widened", 32'(out_widened), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);

        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // FP4 convert 0x3A -> 0x3CB8 (frame pos 0)
        in_valid  = 1'b1;
        in_prec   = 1'b0;
        in_data   = 24'h00003A;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("fp4_valid", 32'(out_valid), 32'h1);
        check("fp4_data", 32'(out_data), 32'h3CB8);
        check("fp4_widened", 32'(out_widened), 32'h1);
        check("fp4_last", 32'(out_last), 32'h0);
        cyc();
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_data_zero", 32'(out_data), 32'h0);

        // FP4 edge values, back to back (frame pos 1, 2)
        in_valid = 1'b1;
        in_data  = 24'h000018;
        cyc();
        check("fp4_sub_zero", 32'(out_data), 32'h3080);
        in_data = 24'h00007F;
        cyc();
        check("fp4_max", 32'(out_data), 32'h4CCC);
        check("fp4_max_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        cyc();
        check("fp4_max_drained", 32'(out_valid), 32'h0);

        // FP8 pass-through (frame pos 3)
        in_valid = 1'b1;
        in_prec  = 1'b1;
        in_data  = 24'hA5C3FF;
        cyc();
        in_valid = 1'b0;
        check("fp8_data", 32'(out_data), 32'hA5C3);
        check("fp8_widened", 32'(out_widened), 32'h0);
        cyc();

        // Backpressure: A, B accepted, C refused until space (frame pos 4, 5, 6)
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_prec   = 1'b1;
        in_data   = 24'h111100;
        cyc();
        check("bp_ready_after_a", 32'(in_ready), 32'h1);
        in_data = 24'h222200;
        cyc();
        check("bp_full_ready", 32'(in_ready), 32'h0);
        check("bp_head_a", 32'(out_data), 32'h1111);
        in_data = 24'h333300;
        cyc();
        check("bp_still_full", 32'(in_ready), 32'h0);
        check("bp_head_stable", 32'(out_data), 32'h1111);
        check("bp_valid_stable", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        cyc();
        check("bp_out_b", 32'(out_data), 32'h2222);
        check("bp_ready_reopen", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        check("bp_out_c", 32'(out_data), 32'h3333);
        check("bp_out_c_valid", 32'(out_valid), 32'h1);
        check("bp_c_not_last", 32'(out_last), 32'h0);
        cyc();
        check("bp_empty", 32'(out_valid), 32'h0);

        // Frame pos 7 closes the first frame despite mixed precisions
        in_valid = 1'b1;
        in_prec  = 1'b0;
        in_data  = 24'h000000;
        cyc();
        in_valid = 1'b0;
        check("frame0_last", 32'(out_last), 32'h1);
        check("signed_zero_pos", 32'(out_data), 32'h0000);
        cyc();

        // 16 back-to-back samples, alternating precision
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            if (i % 2 == 1) begin
                in_prec  = 1'b1;
                in_data  = {8'(i), 8'h5A, 8'h0F};
                exp_data = {8'(i), 8'h5A};
            end else begin
                in_prec  = 1'b0;
                in_data  = 24'hFFEE3A;
                exp_data = 16'h3CB8;
            end
            cyc();
            check($sformatf("frame_valid_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("frame_data_%0d", i), 32'(out_data), 32'(exp_data));
            check($sformatf("frame_last_%0d", i), 32'(out_last),
                  ((i == 7) || (i == 15)) ? 32'h1 : 32'h0);
            check($sformatf("frame_wid_%0d", i), 32'(out_widened),
                  (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        in_valid = 1'b0;
        cyc();
        check("frame_drained", 32'(out_valid), 32'h0);

        // Reset mid-frame with a full FIFO
        in_prec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {8'hC0, 8'(i), 8'h00};
            cyc();
        end
        out_ready = 1'b0;
        in_data   = 24'hD00000;
        cyc();
        in_data = 24'hD10000;
        cyc();
        check("pre_rst_full", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_in_ready_low", 32'(in_ready), 32'h0);
        cyc();
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_data", 32'(out_data), 32'h0);
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = {8'hE0, 8'(i), 8'h00};
            cyc();
            check($sformatf("post_rst_data_%0d", i), 32'(out_data), 32'({8'hE0, 8'(i)}));
            check($sformatf("post_rst_last_%0d", i), 32'(out_last),
                  (i == 7) ? 32'h1 : 32'h0);
        end
        in_valid = 1'b0;
        cyc();
        check("final_empty", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
